mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Parametrised iterative multiply/divide unit with architectural HI/LO registers.
- Adds MULT/MULTU/DIV/DIVU/MTHI/MTLO support to the pipelined core; sits in the EX stage beside the ALU.
- The hazard unit stalls on `busy`; MFHI/MFLO read `hi`/`lo` directly.
- Core operation is radix-2 shift-add or shift-subtract, one bit per cycle.

Parameters:
- XLEN, 32: operand width; HI and LO are each XLEN bits; must be ≥ 4 and even.
- CNT_W, $clog2(XLEN)+1: iteration counter width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous active-high reset
- start  input  1  request a new operation; sampled on rising clk
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- in1  input  XLEN  rs operand: multiplicand or dividend
- in2  input  XLEN  rt operand: multiplier or divisor
- flush  input  1  abort the in-flight operation
- hi_we  input  1  MTHI strobe
- lo_we  input  1  MTLO strobe
- wdata  input  XLEN  MTHI/MTLO data
- busy  output  1  operation in flight
- done  output  1  one-cycle pulse when HI/LO have been updated by an operation
- hi  output  XLEN  HI register
- lo  output  XLEN  LO register

Behaviour:
- Reset is asynchronous and active-high, clock is clk. On reset: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, all datapath registers=0.
- States:
  - IDLE: `busy`=0.
  - CALC: XLEN iterations.
  - FIX: sign correction and HI/LO write.
- `busy` = (state != IDLE), decoded from registered state.
- IDLE→CALC on start && !flush:
  - Latch op.
  - Latch |in1| and |in2| for signed ops (raw values for unsigned).
  - Record result signs.
  - Counter=0.
- CALC: one iteration per edge; after the XLEN-th iteration go to FIX.
- FIX→IDLE: write HI/LO and assert `done` for exactly one cycle.
- Latency: start sampled at edge E0; HI/LO valid and `done`=1 in the cycle following edge E(XLEN+1).
- `start` while busy is ignored; no queuing.
- MULT/MULTU: {hi,lo} = full 2·XLEN-bit product; signed or unsigned per op.
- DIV/DIVU: lo = quotient truncated toward zero, hi = remainder.
  - Signed quotient is negative iff operand signs differ.
  - Signed remainder takes the sign of the dividend.
- Divide by zero (DIV or DIVU): lo = all ones, hi = in1 as originally latched (unmodified dividend).
- Signed overflow MIN/−1: lo = MIN, hi = 0.
- flush:
  - In CALC or FIX: next state IDLE; hi/lo unchanged; no `done`.
  - flush together with start in IDLE: flush wins and start is dropped.
- hi_we/lo_we:
  - Accepted only in IDLE; written on the next edge.
  - Ignored while busy, because the pipeline stalls MTHI/MTLO on `busy`.
- hi_we or lo_we together with start in IDLE: both take effect; the operation result later overwrites HI/LO.
- `done` and the start of a new operation are independent: start may be asserted in the same cycle `done`=1, since state is IDLE.
- Reset asserted mid-operation: immediate return to reset values.

Optional Feature:
- MDU_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle combinational XLEN×XLEN multiplier and go IDLE→FIX directly, skipping CALC.
  - Result valid and `done` in the cycle after edge E1.
  - Divide path unchanged.
- Not defined: all operations use the iterative path with latency XLEN+1.

Test Plan (XLEN=32):
- MULTU in1=0xFFFFFFFF, in2=0xFFFFFFFF → after 33 edges: hi=0xFFFFFFFE, lo=0x00000001, done pulse exactly 1 cycle, busy high for 33 cycles.
- MULT in1=−7 (0xFFFFFFF9), in2=3 → hi=0xFFFFFFFF, lo=0xFFFFFFEB; DIV in1=−7, in2=2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU in1=100, in2=0 → lo=0xFFFFFFFF, hi=100; DIV in1=0x80000000, in2=0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload hi=0x1234 via MTHI; start DIVU 10/3; assert flush at iteration 10 → busy drops next cycle, no done, hi=0x1234, lo unchanged; new start accepted immediately after.
- start asserted while busy (different operands) → ignored; original result delivered. hi_we while busy → hi unaffected. start+flush in same cycle → busy stays 0.
- With MDU_FAST_MUL_EN: MULT 6×7 → lo=42, hi=0, done in the cycle after edge E1; DIVU 42/6 still takes 33 edges → lo=7, hi=0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Optional MDU_FAST_MUL_EN: single-cycle combinational multiplier for MULT/MULTU.
module mult_div_unit #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2} stateT;

`ifdef MDU_FAST_MUL_EN
  localparam bit FastMul = 1'b1;
`else
  localparam bit FastMul = 1'b0;
`endif

  stateT state, nextState;
  logic            startOp;
  logic            writeRes;

  logic [1:0]      opReg;
  logic [XLEN-1:0] opnd;      // multiplicand or divisor magnitude
  logic [XLEN-1:0] accHi;     // partial product high half / remainder
  logic [XLEN-1:0] accLo;     // multiplier bits / dividend-then-quotient
  logic [XLEN-1:0] dvdRaw;    // dividend as given, for the divide-by-zero result
  logic            resNeg;
  logic            remNeg;
  logic            divZero;
  logic [CNT_W-1:0] count;

  logic            startSigned;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   mulSum;
  logic [XLEN:0]   divDiff;
  logic            divOk;
  logic [2*XLEN-1:0] prodRaw, prodFix;
  logic [XLEN-1:0] quo, rem;
  logic [XLEN-1:0] resHi, resLo;

  assign busy = (state != IDLE);

  // Operand magnitudes for signed ops, raw values for unsigned
  assign startSigned = ~op[0];
  assign abs1 = (startSigned && in1[XLEN-1]) ? -in1 : in1;
  assign abs2 = (startSigned && in2[XLEN-1]) ? -in2 : in2;

  // One shift-add / restoring shift-subtract step
  assign mulSum  = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
  assign divDiff = {accHi, accLo[XLEN-1]} - {1'b0, opnd};
  assign divOk   = ~divDiff[XLEN];

`ifdef MDU_FAST_MUL_EN
  assign prodRaw = (2*XLEN)'(opnd) * (2*XLEN)'(accLo);
`else
  assign prodRaw = {accHi, accLo};
`endif

  assign prodFix = resNeg ? -prodRaw : prodRaw;
  assign quo     = resNeg ? -accLo : accLo;
  assign rem     = remNeg ? -accHi : accHi;

  always_comb begin
    resHi = prodFix[2*XLEN-1:XLEN];
    resLo = prodFix[XLEN-1:0];
    if (opReg[1]) begin
      if (divZero) begin
        resHi = dvdRaw;
        resLo = {XLEN{1'b1}};
      end else begin
        resHi = rem;
        resLo = quo;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    startOp   = 1'b0;
    writeRes  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !flush) begin
          startOp   = 1'b1;
          nextState = (FastMul && !op[1]) ? FIX : CALC;
        end
      end
      CALC: begin
        if (flush)                              nextState = IDLE;
        else if (count == CNT_W'(XLEN - 1))     nextState = FIX;
      end
      FIX: begin
        nextState = IDLE;
        writeRes  = !flush;
      end
      default: nextState = IDLE;
    endcase
  end

  // Datapath, counter and architectural HI/LO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opReg   <= 2'b00;
      opnd    <= '0;
      accHi   <= '0;
      accLo   <= '0;
      dvdRaw  <= '0;
      resNeg  <= 1'b0;
      remNeg  <= 1'b0;
      divZero <= 1'b0;
      count   <= '0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= writeRes;
      if (startOp) begin
        opReg   <= op;
        opnd    <= op[1] ? abs2 : abs1;
        accLo   <= op[1] ? abs1 : abs2;
        accHi   <= '0;
        dvdRaw  <= in1;
        resNeg  <= startSigned & (in1[XLEN-1] ^ in2[XLEN-1]);
        remNeg  <= startSigned & in1[XLEN-1];
        divZero <= (in2 == '0);
        count   <= '0;
      end else if (state == CALC) begin
        count <= count + CNT_W'(1);
        if (opReg[1]) begin
          accHi <= divOk ? divDiff[XLEN-1:0] : {accHi[XLEN-2:0], accLo[XLEN-1]};
          accLo <= {accLo[XLEN-2:0], divOk};
        end else begin
          accHi <= mulSum[XLEN:1];
          accLo <= {mulSum[0], accLo[XLEN-1:1]};
        end
      end

      if (writeRes) begin
        hi <= resHi;
        lo <= resLo;
      end else if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule
